// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO (radix-2 shift-add multiply, restoring divide).
// Optional macro MULDIV_DIV_EN builds the divider; without it DIV/DIVU finish in one busy cycle, HI/LO untouched.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-1:0]   a_q, hi_q, lo_q;
    logic [2*DATA_W-1:0] acc_q;
    logic                is_div_q, sign_a_q, sign_b_q, busy_q, done_q;

    logic                signed_op;
    logic [DATA_W-1:0]   abs_in1, abs_in2;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] acc_d, mul_res;
    logic [DATA_W-1:0]   fix_hi_d, fix_lo_d;
`ifdef MULDIV_DIV_EN
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W:0]     div_shift, div_diff;
    logic                div_ge;
`endif

    always_comb begin
        signed_op = ~op[0];
        abs_in1   = (signed_op && in1[DATA_W-1]) ? -in1 : in1;
        abs_in2   = (signed_op && in2[DATA_W-1]) ? -in2 : in2;
        // Multiply: acc holds {partial, multiplier}; add a_q when the multiplier LSB is set, then shift right.
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_d     = {mul_sum, acc_q[DATA_W-1:1]};
        mul_res   = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        fix_hi_d  = mul_res[2*DATA_W-1:DATA_W];
        fix_lo_d  = mul_res[DATA_W-1:0];
`ifdef MULDIV_DIV_EN
        // Divide: acc holds {remainder, dividend/quotient}; shift left one bit and trial-subtract.
        div_shift = acc_q[2*DATA_W-1:DATA_W-1];
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift - {1'b0, b_q};
        if (is_div_q) begin
            acc_d = {(div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                     acc_q[DATA_W-2:0], div_ge};
            if (b_q == '0) begin
                fix_lo_d = '1;
                fix_hi_d = sign_a_q ? -a_q : a_q;
            end else begin
                fix_lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
                fix_hi_d = sign_a_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
            end
        end
`else
        if (is_div_q) begin
            fix_hi_d = hi_q;
            fix_lo_d = lo_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
`ifdef MULDIV_DIV_EN
            b_q      <= '0;
`endif
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Flush outranks everything, including an MTHI/MTLO write in the same cycle.
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                        if (start) begin
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            is_div_q <= op[1];
                            sign_a_q <= signed_op & in1[DATA_W-1];
                            sign_b_q <= signed_op & in2[DATA_W-1];
                            a_q      <= abs_in1;
`ifdef MULDIV_DIV_EN
                            b_q      <= abs_in2;
                            acc_q    <= {{DATA_W{1'b0}}, (op[1] ? abs_in1 : abs_in2)};
                            state_q  <= CALC;
`else
                            acc_q    <= {{DATA_W{1'b0}}, abs_in2};
                            state_q  <= op[1] ? FIX : CALC;
`endif
                        end
                    end
                    CALC: begin
                        acc_q <= acc_d;
                        if (cnt_q == LAST) state_q <= FIX;
                        else               cnt_q   <= cnt_q + 1'b1;
                    end
                    FIX: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= fix_hi_d;
                        lo_q    <= fix_lo_d;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
